pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
//
// PURPOSE
//  Central stall/flush sequencer for the 5-stage scalar/vector ASIP pipeline (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards between ID sources and the EX-stage load destination.
//  - Freezes the pipe while a multi-cycle data-memory access in MEM is outstanding.
//  - Flushes younger stages on a taken branch resolved in EX.
//  - Drives the enable and bubble inputs of every inter-stage register; keeps a stall-cycle counter.
//
// PARAMETERS
//  LOAD_BUBBLES  1   bubbles inserted per load-use hazard (1..7)
//  CNT_W         32  width of the saturating stall-cycle counter
//
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, asynchronous, active-high
//  id_src[3][4]  in   3x4    ID source register indices (src1..src3)
//  id_use        in   3      per-source "source is read" flags
//  id_vf         in   3      per-source file select: 1 = vector file, 0 = scalar file
//  ex_rmem       in   1      EX instruction is a load
//  ex_wreg       in   1      EX instruction writes a register
//  ex_dest       in   4      EX destination index
//  ex_vf         in   1      EX destination file select
//  mem_rmem      in   1      MEM instruction reads memory
//  mem_wmem      in   1      MEM instruction writes memory
//  mem_ready     in   1      data memory completes the MEM access this cycle
//  ex_br_taken   in   1      taken branch/jump resolved in EX
//  stall_if      out  1      hold PC and IF/ID
//  stall_id      out  1      hold ID/EX
//  stall_ex      out  1      hold EX/MEM
//  stall_mem     out  1      hold MEM/WB
//  bubble_ex     out  1      load zeros into ID/EX (NOP)
//  bubble_wb     out  1      load zeros into MEM/WB
//  flush_if      out  1      zero IF/ID
//  stall_cnt     out  CNT_W  stall cycles since reset, saturating
//
// BEHAVIOUR
//  - Reset: state = RUN, bubble counter = 0, stall_cnt = 0, all control outputs 0.
//  - Outputs are combinational from the current state and inputs. State and counters update on posedge clk.
//  - hit_i = id_use[i] & ex_rmem & ex_wreg & (id_vf[i]==ex_vf) & (id_src[i]==ex_dest).
//    - The scalar and vector files never alias.
//    - luh = OR of hit_i.
//  - memw = (mem_rmem | mem_wmem) & ~mem_ready.
//  - Priority, highest first: memw, then luh, then ex_br_taken.
//  - State RUN:
//    - memw: stall_if/id/ex/mem = 1 and bubble_wb = 1. Next state MEM_WAIT.
//    - else luh: stall_if/id = 1 and bubble_ex = 1. Bubble counter = LOAD_BUBBLES-1.
//      Next state LD_STALL if LOAD_BUBBLES > 1, else RUN.
//    - else ex_br_taken: flush_if = 1 and bubble_ex = 1. Stay in RUN.
//  - State MEM_WAIT:
//    - Same outputs as memw. Stay in MEM_WAIT while memw.
//    - Exit on the first mem_ready = 1 cycle, in which all outputs are 0.
//    - Return to RUN; the next cycle re-evaluates luh/branch normally.
//  - State LD_STALL:
//    - stall_if/id = 1 and bubble_ex = 1. Decrement the counter; at 0, next state RUN.
//    - memw arriving in LD_STALL takes priority: MEM_WAIT outputs, next state MEM_WAIT.
//      The remaining bubble count is kept and resumed after MEM_WAIT.
//  - Branch held during MEM_WAIT: the frozen EX keeps ex_br_taken high, so the flush happens on exit.
//    No flush is ever asserted concurrently with stall_ex.
//  - stall_cnt increments every cycle in which stall_if = 1 and saturates at all-ones.
//  - Reset mid-operation: asynchronous return to RUN, counters cleared, outputs 0.
//
// STRUCTURE
//  - Shared package hazard_pkg:
//    - typedef enum logic[1:0] {RUN, MEM_WAIT, LD_STALL} hz_state_t
//    - REG_IDX_W = 4
//    - typedef struct {logic[3:0] idx; logic vf;} reg_ref_t
//  - One sub-module, hazard_match: the combinational per-source comparator producing hit[2:0],
//    instantiated once with 3 lanes.
//  - FSM, bubble counter and stall counter live in the top.
//
// TESTING
//  1. Load to V3 in EX; ID reads V3 (vf = 1) -> one cycle of stall_if/id + bubble_ex, stall_cnt = 1.
//     Reading scalar R3 instead -> no stall.
//  2. Store in MEM with mem_ready low for 3 cycles -> stall_if/id/ex/mem + bubble_wb for exactly 3 cycles,
//     then 0; stall_cnt = 3.
//  3. ex_br_taken alone -> flush_if = 1 and bubble_ex = 1 for 1 cycle, stall_cnt unchanged.
//  4. Load-use hazard and memw together -> MEM_WAIT outputs only. After mem_ready, the held load-use
//     hazard gives 1 bubble.
//  5. LOAD_BUBBLES = 3 with memw for 2 cycles in the 2nd bubble -> 1 bubble, 2 MEM_WAIT cycles,
//     then 2 bubbles; stall_cnt = 5.
//  6. Assert rst during MEM_WAIT -> all outputs 0 immediately, stall_cnt = 0, RUN on release.
//     Force stall_cnt near saturation -> holds at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Register references, FSM states and widths.
package hazard_pkg;

  localparam int REG_IDX_W = 4;
  localparam int BCNT_W    = 3;
  localparam int NSRC      = 3;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    LD_STALL
  } hz_state_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic                 vf;
  } reg_ref_t;

  // Scalar and vector files never alias, so vf must match too.
  function automatic logic same_reg(
    input reg_ref_t a,
    input reg_ref_t b
  );
    return (a.vf == b.vf) && (a.idx == b.idx);
  endfunction

endpackage

// File: rtl/pipeline_hazard_match.sv
// Per-source comparator of ID reads against the EX load destination.
// One hit bit per lane.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int LANES = 3
) (
  input  reg_ref_t [LANES-1:0] src_i,
  input  logic     [LANES-1:0] use_i,
  input  reg_ref_t             ex_i,
  input  logic                 ex_load_i,
  output logic     [LANES-1:0] hit_o
);

  // A lane hits when it reads the register the EX load will write.
  always_comb begin
    hit_o = '0;
    for (int i = 0; i < LANES; i++) begin
      hit_o[i] = use_i[i] & ex_load_i
               & same_reg(src_i[i], ex_i);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Load-use bubbles, memory-wait freeze, branch flush, stall counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NSRC-1:0][REG_IDX_W-1:0]  id_src_i,
  input  logic [NSRC-1:0]                 id_use_i,
  input  logic [NSRC-1:0]                 id_vf_i,
  input  logic                            ex_rmem_i,
  input  logic                            ex_wreg_i,
  input  logic [REG_IDX_W-1:0]            ex_dest_i,
  input  logic                            ex_vf_i,
  input  logic                            mem_rmem_i,
  input  logic                            mem_wmem_i,
  input  logic                            mem_ready_i,
  input  logic                            ex_br_taken_i,
  output logic                            stall_if_o,
  output logic                            stall_id_o,
  output logic                            stall_ex_o,
  output logic                            stall_mem_o,
  output logic                            bubble_ex_o,
  output logic                            bubble_wb_o,
  output logic                            flush_if_o,
  output logic [CNT_W-1:0]                stall_cnt_o
);

  localparam logic [BCNT_W-1:0] BUB_INIT =
    BCNT_W'(LOAD_BUBBLES - 1);
  localparam logic MULTI_BUB = (LOAD_BUBBLES > 1);

  hz_state_t         state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  scnt_q;

  reg_ref_t [NSRC-1:0] src;
  reg_ref_t            ex_ref;
  logic     [NSRC-1:0] hit;
  logic                luh;
  logic                memw;
  logic                frz_front;
  logic                frz_all;
  logic                flush;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign src[g] = '{idx: id_src_i[g],
                      vf:  id_vf_i[g]};
  end

  assign ex_ref = '{idx: ex_dest_i, vf: ex_vf_i};

  hazard_match #(
    .LANES (NSRC)
  ) u_match (
    .src_i     (src),
    .use_i     (id_use_i),
    .ex_i      (ex_ref),
    .ex_load_i (ex_rmem_i & ex_wreg_i),
    .hit_o     (hit)
  );

  assign luh  = |hit;
  assign memw = (mem_rmem_i | mem_wmem_i)
              & ~mem_ready_i;

  // Next state, bubble count and stage controls.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    frz_front = 1'b0;
    frz_all   = 1'b0;
    flush     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (memw) begin
            frz_all = 1'b1;
            state_d = MEM_WAIT;
          end else if (luh) begin
            frz_front = 1'b1;
            bcnt_d    = BUB_INIT;
            state_d   = MULTI_BUB ? LD_STALL : RUN;
          end else if (ex_br_taken_i) begin
            flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (memw) begin
            frz_all = 1'b1;
          end else begin
            state_d = (bcnt_q != '0) ? LD_STALL
                                     : RUN;
          end
        end
        LD_STALL: begin
          if (memw) begin
            frz_all = 1'b1;
            state_d = MEM_WAIT;
          end else begin
            frz_front = 1'b1;
            if (bcnt_q != '0) begin
              bcnt_d = bcnt_q - 1'b1;
            end
            if (bcnt_q <= BCNT_W'(1)) begin
              state_d = RUN;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_if_o  = frz_front | frz_all;
  assign stall_id_o  = frz_front | frz_all;
  assign stall_ex_o  = frz_all;
  assign stall_mem_o = frz_all;
  assign bubble_ex_o = frz_front | flush;
  assign bubble_wb_o = frz_all;
  assign flush_if_o  = flush;
  assign stall_cnt_o = scnt_q;

  // FSM and bubble counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt_q <= '0;
    end else if (stall_if_o && (scnt_q != '1)) begin
      scnt_q <= scnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Vector table plus clocked corner-case sequences.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0][3:0] id_src;
  logic [2:0]      id_use;
  logic [2:0]      id_vf;
  logic            ex_rmem, ex_wreg;
  logic [3:0]      ex_dest;
  logic            ex_vf;
  logic            mem_rmem, mem_wmem;
  logic            mem_ready, br;

  logic a_if, a_id, a_ex, a_mem;
  logic a_bex, a_bwb, a_fl;
  logic [31:0] a_cnt;
  logic b_if, b_id, b_ex, b_mem;
  logic b_bex, b_bwb, b_fl;
  logic [3:0] b_cnt;
  logic [6:0] oa, ob;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LUH  = 7'b1100100;
  localparam logic [6:0] O_MEMW = 7'b1111010;
  localparam logic [6:0] O_BR   = 7'b0000101;

  always #5 clk = ~clk;

  assign oa = {a_if, a_id, a_ex, a_mem,
               a_bex, a_bwb, a_fl};
  assign ob = {b_if, b_id, b_ex, b_mem,
               b_bex, b_bwb, b_fl};

  pipeline_hazard_ctrl #(
    .LOAD_BUBBLES (1),
    .CNT_W        (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_src_i      (id_src),
    .id_use_i      (id_use),
    .id_vf_i       (id_vf),
    .ex_rmem_i     (ex_rmem),
    .ex_wreg_i     (ex_wreg),
    .ex_dest_i     (ex_dest),
    .ex_vf_i       (ex_vf),
    .mem_rmem_i    (mem_rmem),
    .mem_wmem_i    (mem_wmem),
    .mem_ready_i   (mem_ready),
    .ex_br_taken_i (br),
    .stall_if_o    (a_if),
    .stall_id_o    (a_id),
    .stall_ex_o    (a_ex),
    .stall_mem_o   (a_mem),
    .bubble_ex_o   (a_bex),
    .bubble_wb_o   (a_bwb),
    .flush_if_o    (a_fl),
    .stall_cnt_o   (a_cnt)
  );

  pipeline_hazard_ctrl #(
    .LOAD_BUBBLES (3),
    .CNT_W        (4)
  ) dut3 (
    .clk           (clk),
    .rst           (rst),
    .id_src_i      (id_src),
    .id_use_i      (id_use),
    .id_vf_i       (id_vf),
    .ex_rmem_i     (ex_rmem),
    .ex_wreg_i     (ex_wreg),
    .ex_dest_i     (ex_dest),
    .ex_vf_i       (ex_vf),
    .mem_rmem_i    (mem_rmem),
    .mem_wmem_i    (mem_wmem),
    .mem_ready_i   (mem_ready),
    .ex_br_taken_i (br),
    .stall_if_o    (b_if),
    .stall_id_o    (b_id),
    .stall_ex_o    (b_ex),
    .stall_mem_o   (b_mem),
    .bubble_ex_o   (b_bex),
    .bubble_wb_o   (b_bwb),
    .flush_if_o    (b_fl),
    .stall_cnt_o   (b_cnt)
  );

  typedef struct {
    string      nm;
    logic [11:0] src;
    logic [2:0] usef;
    logic [2:0] vf;
    logic       exr, exw;
    logic [3:0] exd;
    logic       exvf;
    logic       mr, mw, rdy, brt;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(string nm,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               nm, got, exp);
    end
  endtask

  task automatic clr();
    id_src    = '0;
    id_use    = '0;
    id_vf     = '0;
    ex_rmem   = 1'b0;
    ex_wreg   = 1'b0;
    ex_dest   = '0;
    ex_vf     = 1'b0;
    mem_rmem  = 1'b0;
    mem_wmem  = 1'b0;
    mem_ready = 1'b0;
    br        = 1'b0;
  endtask

  // EX holds a load to V3, ID reads V3 on src0.
  task automatic set_luh();
    id_src  = 12'h003;
    id_use  = 3'b001;
    id_vf   = 3'b001;
    ex_rmem = 1'b1;
    ex_wreg = 1'b1;
    ex_dest = 4'd3;
    ex_vf   = 1'b1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    clr();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"v3_hit", 12'h003, 3'b001, 3'b001,
                 1, 1, 4'd3, 1, 0, 0, 0, 0, O_LUH};
    vecs[1]  = '{"r3_vs_v3", 12'h003, 3'b001, 3'b000,
                 1, 1, 4'd3, 1, 0, 0, 0, 0, O_NONE};
    vecs[2]  = '{"src2_hit", 12'h512, 3'b101, 3'b000,
                 1, 1, 4'd5, 0, 0, 0, 0, 0, O_LUH};
    vecs[3]  = '{"src2_unused", 12'h512, 3'b011,
                 3'b000, 1, 1, 4'd5, 0, 0, 0, 0, 0,
                 O_NONE};
    vecs[4]  = '{"load_nowreg", 12'h003, 3'b001,
                 3'b001, 1, 0, 4'd3, 1, 0, 0, 0, 0,
                 O_NONE};
    vecs[5]  = '{"alu_in_ex", 12'h003, 3'b001, 3'b001,
                 0, 1, 4'd3, 1, 0, 0, 0, 0, O_NONE};
    vecs[6]  = '{"store_wait", 12'h000, 3'b000,
                 3'b000, 0, 0, 4'd0, 0, 0, 1, 0, 0,
                 O_MEMW};
    vecs[7]  = '{"load_ready", 12'h000, 3'b000,
                 3'b000, 0, 0, 4'd0, 0, 1, 0, 1, 0,
                 O_NONE};
    vecs[8]  = '{"branch", 12'h000, 3'b000, 3'b000,
                 0, 0, 4'd0, 0, 0, 0, 0, 1, O_BR};
    vecs[9]  = '{"luh_over_br", 12'h003, 3'b001,
                 3'b001, 1, 1, 4'd3, 1, 0, 0, 0, 1,
                 O_LUH};
    vecs[10] = '{"memw_over_all", 12'h003, 3'b001,
                 3'b001, 1, 1, 4'd3, 1, 1, 0, 0, 1,
                 O_MEMW};
    vecs[11] = '{"idle_notready", 12'h000, 3'b000,
                 3'b000, 0, 0, 4'd0, 0, 0, 0, 0, 0,
                 O_NONE};

    clr();
    #12;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", 32'(oa), 32'(O_NONE));
    chk("reset_cnt", a_cnt, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_rst();
      id_src    = vecs[i].src;
      id_use    = vecs[i].usef;
      id_vf     = vecs[i].vf;
      ex_rmem   = vecs[i].exr;
      ex_wreg   = vecs[i].exw;
      ex_dest   = vecs[i].exd;
      ex_vf     = vecs[i].exvf;
      mem_rmem  = vecs[i].mr;
      mem_wmem  = vecs[i].mw;
      mem_ready = vecs[i].rdy;
      br        = vecs[i].brt;
      #1;
      chk(vecs[i].nm, 32'(oa), 32'(vecs[i].exp));
    end

    // Single load-use bubble, counted once.
    do_rst();
    set_luh();
    #1;
    chk("t1_bubble", 32'(oa), 32'(O_LUH));
    nxt();
    clr();
    #1;
    chk("t1_after", 32'(oa), 32'(O_NONE));
    chk("t1_cnt", a_cnt, 32'd1);

    // Store waits three cycles.
    do_rst();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nxt();
      mem_wmem = 1'b1;
      #1;
      chk("t2_wait", 32'(oa), 32'(O_MEMW));
      chk("t2_wcnt", a_cnt, 32'(i));
    end
    nxt();
    mem_ready = 1'b1;
    #1;
    chk("t2_exit", 32'(oa), 32'(O_NONE));
    chk("t2_cnt", a_cnt, 32'd3);

    // Branch alone.
    do_rst();
    br = 1'b1;
    #1;
    chk("t3_flush", 32'(oa), 32'(O_BR));
    nxt();
    clr();
    #1;
    chk("t3_after", 32'(oa), 32'(O_NONE));
    chk("t3_cnt", a_cnt, 32'd0);

    // Load-use hidden behind a memory wait.
    do_rst();
    set_luh();
    mem_rmem = 1'b1;
    #1;
    chk("t4_w0", 32'(oa), 32'(O_MEMW));
    nxt();
    #1;
    chk("t4_w1", 32'(oa), 32'(O_MEMW));
    nxt();
    mem_ready = 1'b1;
    #1;
    chk("t4_exit", 32'(oa), 32'(O_NONE));
    nxt();
    mem_rmem  = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("t4_bubble", 32'(oa), 32'(O_LUH));
    nxt();
    clr();
    #1;
    chk("t4_done", 32'(oa), 32'(O_NONE));
    chk("t4_cnt", a_cnt, 32'd3);

    // Branch frozen in EX flushes only after the wait.
    do_rst();
    br       = 1'b1;
    mem_wmem = 1'b1;
    #1;
    chk("tb_w0", 32'(oa), 32'(O_MEMW));
    nxt();
    #1;
    chk("tb_w1", 32'(oa), 32'(O_MEMW));
    nxt();
    mem_ready = 1'b1;
    #1;
    chk("tb_exit", 32'(oa), 32'(O_NONE));
    nxt();
    mem_wmem  = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("tb_flush", 32'(oa), 32'(O_BR));

    // Three bubbles split by a two-cycle wait.
    do_rst();
    set_luh();
    #1;
    chk("t5_b1", 32'(ob), 32'(O_LUH));
    nxt();
    clr();
    mem_rmem = 1'b1;
    #1;
    chk("t5_w1", 32'(ob), 32'(O_MEMW));
    nxt();
    #1;
    chk("t5_w2", 32'(ob), 32'(O_MEMW));
    nxt();
    mem_ready = 1'b1;
    #1;
    chk("t5_exit", 32'(ob), 32'(O_NONE));
    nxt();
    clr();
    #1;
    chk("t5_b2", 32'(ob), 32'(O_LUH));
    nxt();
    #1;
    chk("t5_b3", 32'(ob), 32'(O_LUH));
    nxt();
    #1;
    chk("t5_done", 32'(ob), 32'(O_NONE));
    chk("t5_cnt", 32'(b_cnt), 32'd5);

    // Reset during a memory wait.
    do_rst();
    mem_wmem = 1'b1;
    nxt();
    #1;
    chk("t6_wait", 32'(oa), 32'(O_MEMW));
    chk("t6_wcnt", a_cnt, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 32'(oa), 32'(O_NONE));
    chk("t6_rst_cnt", a_cnt, 32'd0);
    nxt();
    clr();
    rst = 1'b0;
    br  = 1'b1;
    #1;
    chk("t6_run", 32'(oa), 32'(O_BR));

    // Saturation of the narrow counter.
    do_rst();
    mem_wmem = 1'b1;
    for (int i = 0; i < 20; i++) nxt();
    #1;
    chk("sat_cnt", 32'(b_cnt), 32'hF);
    chk("wide_cnt", a_cnt, 32'd20);
    nxt();
    #1;
    chk("sat_hold", 32'(b_cnt), 32'hF);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
